reg_file: RTL and testbench

- Parametrised multi-entry successor to the single enabled register.
- Array of 2**ADDR_W words of N bits each, with two combinational read ports and one synchronous write port.
- Optional hardwired-zero entry 0.
- Serves as the general-purpose register file of the datapath: the decoder drives the read addresses, and writeback drives the write port.

---
 rtl/reg_file.sv | 110 +++++++++++
 tb/tb_reg_file.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//   General-purpose register file of the datapath: 2**ADDR_W words of N bits,
//   two combinational read ports, one synchronous write port, and a saturating
//   count of committed writes. Entry 0 can be hardwired to zero (ZERO_REG=1).
//
// Parameters
//   N          data word width in bits
//   ADDR_W     address width; depth = 2**ADDR_W entries
//   ZERO_REG   1: entry 0 reads 0 and ignores writes; 0: ordinary register
//   RESET_VAL  value loaded into every entry on reset
//
// Ports
//   clk     in   clock; all state changes on posedge
//   reset   in   synchronous, active-high reset (priority over enable)
//   enable  in   write enable
//   wa, wd  in   write address / write data
//   ra1/ra2 in   read addresses
//   rd1/rd2 out  read data (combinational)
//   wcount  out  committed writes since reset, saturating at 16'hFFFF
//
// Build option
//   REGFILE_BYPASS_EN  when defined, a write in progress is forwarded to any
//                      read port addressing the same entry in the same cycle.
// ---------------------------------------------------------------------------
module reg_file #(
    parameter int             N         = 32,
    parameter int             ADDR_W    = 5,
    parameter int             ZERO_REG  = 1,
    parameter logic [N-1:0]   RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] wa,
    input  logic [N-1:0]      wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [N-1:0]      rd1,
    output logic [N-1:0]      rd2,
    output logic [15:0]       wcount
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [N-1:0] r_mem [DEPTH];
    logic [15:0]  r_wcount;

    logic         w_wa_is_zero_reg;
    logic         w_commit;
    logic [N-1:0] w_rd1;
    logic [N-1:0] w_rd2;

    // A write to the hardwired-zero entry is not a committed write: it neither
    // updates storage nor advances the counter.
    assign w_wa_is_zero_reg = (ZERO_REG != 0) && (wa == '0);
    assign w_commit         = enable && !w_wa_is_zero_reg;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the whole array is reset because software relies on a
            // known register state; this forces flops rather than a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                // The zero entry is never observable, so it is cleared to a
                // defined value instead of RESET_VAL.
                if ((ZERO_REG != 0) && (i == 0)) begin
                    r_mem[i] <= '0;
                end else begin
                    r_mem[i] <= RESET_VAL;
                end
            end
            r_wcount <= '0;
        end else if (w_commit) begin
            r_mem[wa] <= wd;
            if (r_wcount != 16'hFFFF) begin
                r_wcount <= r_wcount + 16'd1;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_rd1 = r_mem[ra1];
        w_rd2 = r_mem[ra2];
`ifdef REGFILE_BYPASS_EN
        // Write-through: reads see the value being written this cycle.
        if (enable && !reset && (ra1 == wa)) begin
            w_rd1 = wd;
        end
        if (enable && !reset && (ra2 == wa)) begin
            w_rd2 = wd;
        end
`endif
        // Applied last so it also suppresses forwarding to entry 0.
        if ((ZERO_REG != 0) && (ra1 == '0)) begin
            w_rd1 = '0;
        end
        if ((ZERO_REG != 0) && (ra2 == '0)) begin
            w_rd2 = '0;
        end
    end

    assign rd1    = w_rd1;
    assign rd2    = w_rd2;
    assign wcount = r_wcount;

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
//   Self-checking bench for reg_file (N=32, ADDR_W=5, ZERO_REG=1,
//   RESET_VAL=0). Directed scenarios plus randomized traffic, compared with a
//   behavioural model: an array of words and an integer write counter.
// ---------------------------------------------------------------------------
module tb_reg_file;

    localparam int N     = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [AW-1:0] wa;
    logic [N-1:0]  wd;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [N-1:0]  rd1;
    logic [N-1:0]  rd2;
    logic [15:0]   wcount;

    always #5 clk = ~clk;

    reg_file #(
        .N        (N),
        .ADDR_W   (AW),
        .ZERO_REG (1),
        .RESET_VAL('0)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .wa     (wa),
        .wd     (wd),
        .ra1    (ra1),
        .ra2    (ra2),
        .rd1    (rd1),
        .rd2    (rd2),
        .wcount (wcount)
    );

    // Reference model
    logic [N-1:0] model_mem [DEPTH];
    int           model_wc;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected read data for an address given the current inputs.
    function automatic logic [N-1:0] expect_rd(input logic [AW-1:0] ra);
        if (ra == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (enable && !reset && ra == wa) return wd;
`endif
        return model_mem[ra];
    endfunction

    // Advance one clock edge, applying the current inputs to the model.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
            model_wc = 0;
        end else if (enable && wa != 0) begin
            model_mem[wa] = wd;
            if (model_wc < 65535) model_wc = model_wc + 1;
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        #2;
        check({tag, "/rd1"},    rd1, expect_rd(ra1));
        check({tag, "/rd2"},    rd2, expect_rd(ra2));
        check({tag, "/wcount"}, {16'd0, wcount}, model_wc[31:0]);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 'x;
        model_wc = 0;
        @(negedge clk);
        tick();
        reset = 1'b0;

        // 1: reset state
        ra1 = 5'd3; ra2 = 5'd31; #2;
        check("t1/rd1", rd1, 32'h0);
        check("t1/rd2", rd2, 32'h0);
        check("t1/wcount", {16'd0, wcount}, 32'd0);

        // 2: basic write, dual read of same entry, enable=0 holds
        enable = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        tick();
        enable = 1'b0; ra1 = 5'd5; ra2 = 5'd5; #2;
        check("t2/rd1", rd1, 32'hDEADBEEF);
        check("t2/rd2", rd2, 32'hDEADBEEF);
        check("t2/wcount", {16'd0, wcount}, 32'd1);
        wd = 32'd7;
        tick();
        #2;
        check("t2/hold_rd1", rd1, 32'hDEADBEEF);
        check("t2/hold_wcount", {16'd0, wcount}, 32'd1);

        // 3: write to hardwired-zero entry is discarded and not counted
        enable = 1'b1; wa = 5'd0; wd = 32'd99;
        tick();
        enable = 1'b0; ra1 = 5'd0; #2;
        check("t3/rd1", rd1, 32'h0);
        check("t3/wcount", {16'd0, wcount}, 32'd1);

        // 4: reset beats a simultaneous write
        enable = 1'b1; wa = 5'd2; wd = 32'd44;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; enable = 1'b0; ra1 = 5'd2; ra2 = 5'd5; #2;
        check("t4/rd1", rd1, 32'h0);
        check("t4/rd2", rd2, 32'h0);
        check("t4/wcount", {16'd0, wcount}, 32'd0);

        // 5: same-cycle read and write of the same address
        ra1 = 5'd9; wa = 5'd9; wd = 32'd123; enable = 1'b1; #2;
`ifdef REGFILE_BYPASS_EN
        check("t5/pre_edge", rd1, 32'd123);
`else
        check("t5/pre_edge", rd1, 32'd0);
`endif
        tick();
        enable = 1'b0; #2;
        check("t5/post_edge", rd1, 32'd123);

        // Randomized traffic; reads checked both before and after each edge
        for (int it = 0; it < 400; it++) begin
            reset  = ($urandom_range(0, 39) == 0);
            enable = $urandom_range(0, 1);
            wa     = AW'($urandom_range(0, DEPTH - 1));
            wd     = $urandom;
            ra1    = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
            ra2    = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
            check_all($sformatf("rand%0d/pre", it));
            tick();
            reset = 1'b0; enable = 1'b0;
            check_all($sformatf("rand%0d/post", it));
        end

        // 6: counter saturation
        reset = 1'b1;
        tick();
        reset = 1'b0; enable = 1'b1; wa = 5'd1;
        for (int i = 0; i < 65540; i++) begin
            wd = i;
            tick();
        end
        enable = 1'b0; ra1 = 5'd1; ra2 = 5'd0; #2;
        check("t6/wcount", {16'd0, wcount}, 32'h0000FFFF);
        check("t6/rd1", rd1, 32'd65539);
        check("t6/rd2", rd2, 32'h0);
        check_all("t6/model");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
